serial_add_unit: RTL



---
 rtl/serial_add_unit_pkg.sv | 20 ++
 rtl/full_adder_cell.sv | 17 +
 rtl/serial_add_unit.sv | 114 +++++++++++
 3 files changed

// File: rtl/serial_add_unit_pkg.sv
// Shared types and constants for the bit-serial adder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state type, default operand width, counter-width helper.
package serial_add_unit_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Bit counter only needs to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder, the one arithmetic cell of the serial adder.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake.
//
// Ports: a, b, cin -> s (sum bit), cout (carry out).
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_unit.sv
// Bit-serial adder: WIDTH-bit sum produced LSB-first through one full-adder cell.
// Latency: WIDTH cycles from the accepting edge to the one-cycle done pulse.
// Backpressure: start is only sampled while busy=0; start during busy is dropped.
//
// Ports: clk, rst_n (async active-low); start, a, b (and sub when SERIAL_SUB_EN
// is defined) in; busy, done, sum, carry_out out, all registered.
// Optional feature macro: SERIAL_SUB_EN adds the sub port (a-b, carry_out = borrow).
module serial_add_unit
  import serial_add_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Only WIDTH-1 partial bits are stored; the final bit joins them on the last edge.
  logic [WIDTH-2:0] res_sh;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             sub_mode;
  logic             fa_s;
  logic             fa_cout;
  logic [WIDTH-1:0] res_cat;

`ifdef SERIAL_SUB_EN
  logic sub_q;
  assign sub_mode = sub_q;
`else
  assign sub_mode = 1'b0;
`endif

  // Subtract uses a + ~b + 1: invert b here, the +1 comes from the carry seed.
  full_adder_cell u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0] ^ sub_mode),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // New sum bit enters from the MSB side so bit 0 ends up at sum[0].
  assign res_cat = {fa_s, res_sh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
`ifdef SERIAL_SUB_EN
      sub_q     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            res_sh <= '0;
            cnt    <= '0;
`ifdef SERIAL_SUB_EN
            sub_q  <= sub;
            carry  <= sub;
`else
            carry  <= 1'b0;
`endif
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_cat[WIDTH-1:1];
          carry  <= fa_cout;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            sum       <= res_cat;
            // In subtract mode the raw carry is the inverse of the borrow.
            carry_out <= fa_cout ^ sub_mode;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
